vf_pattern_gen: RTL and testbench

//  Parametrised video-frame test-pattern source for usb_camera_top's vf_sof/vf_req/vf_byte fetch port.

---
 rtl/vf_pattern_pkg.sv | 37 +++
 rtl/vf_frame_cnt.sv | 88 ++++++++
 rtl/vf_pattern_gen.sv | 125 ++++++++++++
 tb/tb_vf_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vf_pattern_pkg.sv
// Shared definitions for the video-frame pattern source: mode encodings,
// luma/chroma levels and the eight-entry colour-bar table.
package vf_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } mode_e;

    localparam logic [7:0] Y_HI  = 8'd235;
    localparam logic [7:0] Y_LO  = 8'd16;
    localparam logic [7:0] C_MID = 8'd128;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    function automatic yuv_t bar_colour(input logic [2:0] bar);
        yuv_t c;
        case (bar)
            3'd0:    c = '{y: 8'd235, u: 8'd128, v: 8'd128};  // white
            3'd1:    c = '{y: 8'd210, u: 8'd16,  v: 8'd146};  // yellow
            3'd2:    c = '{y: 8'd170, u: 8'd166, v: 8'd16};   // cyan
            3'd3:    c = '{y: 8'd145, u: 8'd54,  v: 8'd34};   // green
            3'd4:    c = '{y: 8'd106, u: 8'd202, v: 8'd222};  // magenta
            3'd5:    c = '{y: 8'd81,  u: 8'd90,  v: 8'd240};  // red
            3'd6:    c = '{y: 8'd41,  u: 8'd240, v: 8'd110};  // blue
            default: c = '{y: 8'd16,  u: 8'd128, v: 8'd128};  // black
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vf_frame_cnt.sv
// Pixel/line/phase position counters for one frame, with end-of-frame
// detection, the frame_done pulse and the sticky overrun flag.
module vf_frame_cnt #(
    parameter string       FRAME_TYPE = "MONO",
    parameter logic [13:0] FRAME_W    = 14'd252,
    parameter logic [13:0] FRAME_H    = 14'd120
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sof,
    input  logic        req,
    output logic [13:0] x_d,
    output logic [13:0] y_d,
    output logic [1:0]  phase_d,
    output logic        wrap,
    output logic        frame_done,
    output logic        ovf
);
    localparam bit IS_YUY2 = (FRAME_TYPE == "YUY2");

    logic [13:0] x_q, y_q;
    logic [1:0]  phase_q;
    logic        ended_q, ended_d;
    logic        frame_done_q, frame_done_d;
    logic        ovf_q, ovf_d;
    logic        last, x_inc;

    always_comb begin
        // NOTE: every combinational output is given a default first so no latch is inferred.
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        ended_d      = ended_q;
        ovf_d        = ovf_q;
        frame_done_d = 1'b0;
        wrap         = 1'b0;

        // In YUY2 the final V byte sits at phase 3 after x and y have both wrapped.
        last  = IS_YUY2 ? (phase_q == 2'd3 && x_q == 14'd0 && y_q == 14'd0)
                        : (x_q == FRAME_W - 14'd1 && y_q == FRAME_H - 14'd1);
        x_inc = IS_YUY2 ? !phase_q[0] : 1'b1;

        if (sof) begin
            x_d     = 14'd0;
            y_d     = 14'd0;
            phase_d = 2'd0;
            ended_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (req) begin
            wrap         = last;
            frame_done_d = last;
            ended_d      = ended_q | last;
            ovf_d        = ovf_q | ended_q;
            if (IS_YUY2) phase_d = phase_q + 2'd1;
            if (x_inc) begin
                if (x_q == FRAME_W - 14'd1) begin
                    x_d = 14'd0;
                    y_d = (y_q == FRAME_H - 14'd1) ? 14'd0 : y_q + 14'd1;
                end else begin
                    x_d = x_q + 14'd1;
                end
            end
        end
    end

    // NOTE: reset is synchronous, so rstn is tested inside the clocked block only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_q          <= 14'd0;
            y_q          <= 14'd0;
            phase_q      <= 2'd0;
            ended_q      <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            ended_q      <= ended_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/vf_pattern_gen.sv
// Video-frame test-pattern source: per-frame seed, mode and box position,
// and the registered byte mux fed from next-state frame counters.
module vf_pattern_gen
    import vf_pattern_pkg::*;
#(
    parameter string       FRAME_TYPE = "MONO",
    parameter logic [13:0] FRAME_W    = 14'd252,
    parameter logic [13:0] FRAME_H    = 14'd120,
    parameter int          CHECK_LOG2 = 4,
    parameter int          BOX_SZ     = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] mode,
    input  logic       vf_sof,
    input  logic       vf_req,
    output logic [7:0] vf_byte,
    output logic [7:0] frame_cnt,
    output logic       frame_done,
    output logic       ovf
);
    localparam bit IS_YUY2 = (FRAME_TYPE == "YUY2");

    mode_e       mode_q, mode_d;
    logic [7:0]  seed_q, seed_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  vf_byte_q, vf_byte_d;
    logic [13:0] bx_q, bx_d, by_q, by_d;
    logic [13:0] x_d, y_d, bar_x;
    logic [1:0]  phase_d;
    logic        wrap, chroma, checker_lo, box_in;
    logic [2:0]  bar;
    yuv_t        bar_c;
    logic [7:0]  pix;

    vf_frame_cnt #(
        .FRAME_TYPE(FRAME_TYPE),
        .FRAME_W   (FRAME_W),
        .FRAME_H   (FRAME_H)
    ) u_frame_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .sof       (vf_sof),
        .req       (vf_req),
        .x_d       (x_d),
        .y_d       (y_d),
        .phase_d   (phase_d),
        .wrap      (wrap),
        .frame_done(frame_done),
        .ovf       (ovf)
    );

    always_comb begin
        mode_d      = mode_q;
        seed_d      = seed_q;
        frame_cnt_d = frame_cnt_q;
        bx_d        = bx_q;
        by_d        = by_q;
        k_d         = k_q;
        if (vf_sof) begin
            mode_d      = mode_e'(mode);
            seed_d      = frame_cnt_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            bx_d        = (bx_q == FRAME_W - 14'd1) ? 14'd0 : bx_q + 14'd1;
            by_d        = (by_q == FRAME_H - 14'd1) ? 14'd0 : by_q + 14'd1;
            k_d         = 8'd0;
        end else if (vf_req) begin
            k_d = wrap ? 8'd0 : k_q + 8'd1;
        end
    end

    always_comb begin
        // Chroma bytes take their bar from the even pixel of the pair; V trails x by two.
        bar_x = x_d;
        if (IS_YUY2 && phase_d == 2'd1)
            bar_x = x_d - 14'd1;
        else if (IS_YUY2 && phase_d == 2'd3)
            bar_x = (x_d == 14'd0) ? FRAME_W - 14'd2 : x_d - 14'd2;

        bar = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if ({4'd0, bar_x, 3'd0} >= 21'(b) * 21'(FRAME_W)) bar = 3'(b);
        end
        bar_c = bar_colour(bar);

        chroma     = IS_YUY2 && phase_d[0];
        checker_lo = x_d[CHECK_LOG2] ^ y_d[CHECK_LOG2] ^ seed_d[0];
        box_in     = ({1'b0, x_d} >= {1'b0, bx_d}) && ({1'b0, x_d} < {1'b0, bx_d} + 15'(BOX_SZ)) &&
                     ({1'b0, y_d} >= {1'b0, by_d}) && ({1'b0, y_d} < {1'b0, by_d} + 15'(BOX_SZ));

        case (mode_d)
            MODE_RAMP:    pix = seed_d + k_d;
            MODE_BARS:    pix = !chroma ? bar_c.y : ((phase_d == 2'd1) ? bar_c.u : bar_c.v);
            MODE_CHECKER: pix = chroma ? C_MID : (checker_lo ? Y_LO : Y_HI);
            default:      pix = chroma ? C_MID : (box_in ? Y_HI : Y_LO);
        endcase

        vf_byte_d = (vf_sof || vf_req) ? pix : vf_byte_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_q      <= MODE_RAMP;
            seed_q      <= 8'd0;
            frame_cnt_q <= 8'd0;
            k_q         <= 8'd0;
            bx_q        <= 14'd0;
            by_q        <= 14'd0;
            vf_byte_q   <= 8'd0;
        end else begin
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            frame_cnt_q <= frame_cnt_d;
            k_q         <= k_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            vf_byte_q   <= vf_byte_d;
        end
    end

    assign vf_byte   = vf_byte_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vf_pattern_gen.sv
// Bench for vf_pattern_gen: three configurations driven in lockstep and checked
// against a byte-index reference model, plus vector tables and directed sequences.
module tb_vf_pattern_gen;

    localparam int NCFG = 3;
    localparam int CW [NCFG] = '{252, 16, 16};
    localparam int CH [NCFG] = '{120, 2, 4};
    localparam int CL [NCFG] = '{4, 4, 2};
    localparam int CB [NCFG] = '{16, 8, 4};
    localparam int CY [NCFG] = '{0, 1, 0};

    localparam logic [7:0] TY [8] = '{8'd235, 8'd210, 8'd170, 8'd145, 8'd106, 8'd81, 8'd41, 8'd16};
    localparam logic [7:0] TU [8] = '{8'd128, 8'd16, 8'd166, 8'd54, 8'd202, 8'd90, 8'd240, 8'd128};
    localparam logic [7:0] TV [8] = '{8'd128, 8'd146, 8'd16, 8'd34, 8'd222, 8'd240, 8'd110, 8'd128};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, sof, req;
    logic [1:0] mode     [NCFG];
    logic [7:0] act_byte [NCFG];
    logic [7:0] act_fc   [NCFG];
    logic       act_done [NCFG];
    logic       act_ovf  [NCFG];

    vf_pattern_gen #(.FRAME_TYPE("MONO"), .FRAME_W(14'd252), .FRAME_H(14'd120),
                     .CHECK_LOG2(4), .BOX_SZ(16)) u_dut_a (
        .clk(clk), .rstn(rstn), .mode(mode[0]), .vf_sof(sof), .vf_req(req),
        .vf_byte(act_byte[0]), .frame_cnt(act_fc[0]), .frame_done(act_done[0]), .ovf(act_ovf[0]));

    vf_pattern_gen #(.FRAME_TYPE("YUY2"), .FRAME_W(14'd16), .FRAME_H(14'd2),
                     .CHECK_LOG2(4), .BOX_SZ(8)) u_dut_b (
        .clk(clk), .rstn(rstn), .mode(mode[1]), .vf_sof(sof), .vf_req(req),
        .vf_byte(act_byte[1]), .frame_cnt(act_fc[1]), .frame_done(act_done[1]), .ovf(act_ovf[1]));

    vf_pattern_gen #(.FRAME_TYPE("MONO"), .FRAME_W(14'd16), .FRAME_H(14'd4),
                     .CHECK_LOG2(2), .BOX_SZ(4)) u_dut_c (
        .clk(clk), .rstn(rstn), .mode(mode[2]), .vf_sof(sof), .vf_req(req),
        .vf_byte(act_byte[2]), .frame_cnt(act_fc[2]), .frame_done(act_done[2]), .ovf(act_ovf[2]));

    int checks = 0;
    int failures = 0;

    int m_fc [NCFG], m_seed [NCFG], m_mode [NCFG], m_bx [NCFG], m_by [NCFG], m_k [NCFG];
    int m_ended [NCFG], m_ovf [NCFG], m_done [NCFG], m_byte [NCFG];

    typedef struct {
        bit         sof;
        bit         req;
        logic [7:0] exp_b;
        logic [7:0] exp_c;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d: got %0d, expected %0d (t=%0t)", name, c, act, exp, $time);
        end
    endtask

    function automatic int frame_len(input int c);
        return CW[c] * CH[c] * (CY[c] != 0 ? 2 : 1);
    endfunction

    function automatic int bar_of(input int w, input int x);
        for (int b = 7; b >= 1; b--) begin
            if (x * 8 >= b * w) return b;
        end
        return 0;
    endfunction

    // Byte k of the frame, derived from pixel/line position of the byte index.
    function automatic int exp_byte(input int c);
        int k, x, y, xe, pos, pairs;
        bit hit;
        k = m_k[c];
        pos = 0;
        if (CY[c] == 0) begin
            x  = k % CW[c];
            y  = (k / CW[c]) % CH[c];
            xe = x;
        end else begin
            pairs = CW[c] / 2;
            pos   = k % 4;
            xe    = 2 * ((k / 4) % pairs);
            y     = ((k / 4) / pairs) % CH[c];
            x     = (pos == 2) ? xe + 1 : xe;
        end
        case (m_mode[c])
            0: return (m_seed[c] + k) % 256;
            1: begin
                if (pos == 1) return int'(TU[bar_of(CW[c], xe)]);
                if (pos == 3) return int'(TV[bar_of(CW[c], xe)]);
                return int'(TY[bar_of(CW[c], x)]);
            end
            2: begin
                if (pos % 2 == 1) return 128;
                return ((((x >> CL[c]) ^ (y >> CL[c]) ^ m_seed[c]) & 1) != 0) ? 16 : 235;
            end
            default: begin
                if (pos % 2 == 1) return 128;
                hit = (x >= m_bx[c]) && (x < m_bx[c] + CB[c]) && (y >= m_by[c]) && (y < m_by[c] + CB[c]);
                return hit ? 235 : 16;
            end
        endcase
    endfunction

    task automatic model_update();
        for (int c = 0; c < NCFG; c++) begin
            if (!rstn) begin
                m_fc[c] = 0; m_seed[c] = 0; m_mode[c] = 0; m_bx[c] = 0; m_by[c] = 0;
                m_k[c] = 0; m_ended[c] = 0; m_ovf[c] = 0; m_done[c] = 0; m_byte[c] = 0;
            end else if (sof) begin
                m_seed[c]  = m_fc[c];
                m_fc[c]    = (m_fc[c] + 1) % 256;
                m_mode[c]  = int'(mode[c]);
                m_bx[c]    = (m_bx[c] + 1) % CW[c];
                m_by[c]    = (m_by[c] + 1) % CH[c];
                m_k[c]     = 0;
                m_ended[c] = 0;
                m_ovf[c]   = 0;
                m_done[c]  = 0;
                m_byte[c]  = exp_byte(c);
            end else if (req) begin
                m_done[c] = (m_k[c] == frame_len(c) - 1) ? 1 : 0;
                if (m_ended[c] != 0) m_ovf[c] = 1;
                if (m_done[c] != 0) m_ended[c] = 1;
                m_k[c]    = (m_k[c] + 1) % frame_len(c);
                m_byte[c] = exp_byte(c);
            end else begin
                m_done[c] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCFG; c++) begin
            check("vf_byte", c, 32'(act_byte[c]), m_byte[c]);
            check("frame_cnt", c, 32'(act_fc[c]), m_fc[c]);
            check("frame_done", c, 32'(act_done[c]), m_done[c]);
            check("ovf", c, 32'(act_ovf[c]), m_ovf[c]);
        end
    endtask

    task automatic cycle(input bit s, input bit r, input bit chk);
        sof = s;
        req = r;
        @(posedge clk);
        model_update();
        #1;
        if (chk) compare_all();
    endtask

    task automatic set_modes(input logic [1:0] ma, input logic [1:0] mb, input logic [1:0] mc);
        mode[0] = ma;
        mode[1] = mb;
        mode[2] = mc;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 8'd235, 8'd235};
        vt[1]  = '{1'b0, 1'b1, 8'd128, 8'd235};
        vt[2]  = '{1'b0, 1'b1, 8'd235, 8'd235};
        vt[3]  = '{1'b0, 1'b1, 8'd128, 8'd235};
        vt[4]  = '{1'b0, 1'b1, 8'd210, 8'd16};
        vt[5]  = '{1'b0, 1'b1, 8'd16,  8'd16};
        vt[6]  = '{1'b0, 1'b1, 8'd210, 8'd16};
        vt[7]  = '{1'b0, 1'b1, 8'd146, 8'd16};
        vt[8]  = '{1'b1, 1'b0, 8'd235, 8'd16};
        vt[9]  = '{1'b0, 1'b1, 8'd128, 8'd16};
        vt[10] = '{1'b0, 1'b1, 8'd235, 8'd16};
        vt[11] = '{1'b0, 1'b1, 8'd128, 8'd16};

        rstn = 1'b0;
        sof  = 1'b0;
        req  = 1'b0;
        set_modes(2'd0, 2'd0, 2'd0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_byte", 0, 32'(act_byte[0]), 0);
        check("reset_fc", 0, 32'(act_fc[0]), 0);
        rstn = 1'b1;

        // Legacy ramp over 300 bytes, then second frame starts one higher.
        cycle(1'b1, 1'b0, 1'b1);
        check("ramp_byte0", 0, 32'(act_byte[0]), 0);
        check("ramp_fc1", 0, 32'(act_fc[0]), 1);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b1);
        check("ramp_300", 0, 32'(act_byte[0]), 300 % 256);
        cycle(1'b1, 1'b0, 1'b1);
        check("ramp_sof2_byte0", 0, 32'(act_byte[0]), 1);
        check("ramp_sof2_fc", 0, 32'(act_fc[0]), 2);

        // Vector table: YUY2 bars on cfg1, checker on cfg2, from a clean reset.
        rstn = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        rstn = 1'b1;
        set_modes(2'd3, 2'd1, 2'd2);
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].sof, vt[i].req, 1'b1);
            check("tbl_yuy2_bars", 1, 32'(act_byte[1]), 32'(vt[i].exp_b));
            check("tbl_checker", 2, 32'(act_byte[2]), 32'(vt[i].exp_c));
        end

        // Mid-frame mode change is ignored; sof+req together acts as sof only.
        set_modes(2'd0, 2'd0, 2'd0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1);
        set_modes(2'd1, 2'd1, 2'd1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1);
        check("mode_hold_ramp", 0, 32'(act_byte[0]), 42);
        set_modes(2'd0, 2'd0, 2'd0);
        cycle(1'b1, 1'b1, 1'b1);
        check("sof_req_byte0", 0, 32'(act_byte[0]), 3);
        cycle(1'b0, 1'b1, 1'b1);
        check("sof_req_next", 0, 32'(act_byte[0]), 4);

        // Randomized traffic on all configurations.
        for (int i = 0; i < 4000; i++) begin
            rstn = ($urandom_range(0, 999) != 0);
            for (int c = 0; c < NCFG; c++) mode[c] = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), 1'b1);
        end
        rstn = 1'b1;

        // Full MONO 252x120 frame: frame_done, overrun, overrun cleared by sof.
        rstn = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        rstn = 1'b1;
        set_modes(2'd0, 2'd0, 2'd0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 30240; i++) cycle(1'b0, 1'b1, (i > 30235));
        check("full_frame_done", 0, 32'(act_done[0]), 1);
        check("full_frame_byte0", 0, 32'(act_byte[0]), 0);
        check("full_frame_no_ovf", 0, 32'(act_ovf[0]), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("done_is_pulse", 0, 32'(act_done[0]), 0);
        cycle(1'b0, 1'b1, 1'b1);
        check("ovf_set", 0, 32'(act_ovf[0]), 1);
        cycle(1'b0, 1'b0, 1'b1);
        check("ovf_sticky", 0, 32'(act_ovf[0]), 1);
        cycle(1'b1, 1'b0, 1'b1);
        check("ovf_clear", 0, 32'(act_ovf[0]), 0);

        // Reset at k=500 mid-frame, then a fresh frame starts from seed 0.
        for (int i = 0; i < 500; i++) cycle(1'b0, 1'b1, (i > 495));
        check("pre_reset_byte", 0, 32'(act_byte[0]), (1 + 500) % 256);
        rstn = 1'b0;
        cycle(1'b0, 1'b1, 1'b1);
        check("midreset_byte", 0, 32'(act_byte[0]), 0);
        check("midreset_fc", 0, 32'(act_fc[0]), 0);
        rstn = 1'b1;
        cycle(1'b1, 1'b0, 1'b1);
        check("post_reset_byte0", 0, 32'(act_byte[0]), 0);
        check("post_reset_fc", 0, 32'(act_fc[0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
